tap_controller: RTL and testbench
=================================

TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameters: none.
REQ-002 tck  input  1  JTAG test clock; the single clock, both edges used.
REQ-003 trstn  input  1  asynchronous active-low reset.
REQ-004 tms  input  1  test mode select, sampled on posedge tck.
REQ-005 select_dr  input  1  from instruction_register; 1 = route DR path to TDO, 0 = route IR path to TDO.
REQ-006 ir_tdo  input  1  serial output of instruction_register.
REQ-007 dr_tdo  input  1  serial output of the selected data register.
REQ-008 tap_state  output  tap_ctrl_fsm_t  current controller state.
REQ-009 tdo  output  1  registered serial output to the pin.
REQ-010 tdo_en  output  1  TDO driver enable, high only while shifting.
REQ-011 capture_dr, shift_dr, update_dr  output  1 each  decoded DR-phase strobes, combinational from tap_state.
REQ-012 tlr  output  1  high while tap_state == TEST_LOGIC_RESET.

Function
REQ-013 The FSM SHALL be the 16-state IEEE 1149.1 TAP controller, advancing on posedge tck from the current state and tms.
REQ-014 With tms=1, transitions SHALL be: TLR->TLR, RTI->SEL_DR, SEL_DR->SEL_IR, SEL_IR->TLR, CAP_x->EXIT1_x, SHIFT_x->EXIT1_x, EXIT1_x->UPD_x, PAUSE_x->EXIT2_x, EXIT2_x->UPD_x, UPD_x->SEL_DR.
REQ-015 With tms=0, transitions SHALL be: TLR->RTI, RTI->RTI, SEL_DR->CAP_DR, SEL_IR->CAP_IR, CAP_x->SHIFT_x, SHIFT_x->SHIFT_x, EXIT1_x->PAUSE_x, PAUSE_x->PAUSE_x, EXIT2_x->SHIFT_x, UPD_x->RTI.
REQ-016 Five consecutive posedges with tms=1 SHALL reach TEST_LOGIC_RESET from any state.
REQ-017 Unreachable or corrupted encodings SHALL transition to TEST_LOGIC_RESET on the next posedge.
REQ-018 The TDO mux SHALL select ir_tdo when select_dr=0, and dr_tdo otherwise.
REQ-019 tdo and tdo_en SHALL update only on negedge tck.
REQ-020 At each negedge, tdo_en SHALL load 1 if tap_state is SHIFT_DR or SHIFT_IR, and 0 otherwise.
REQ-021 At each negedge, tdo SHALL load the mux output when shifting; otherwise it SHALL hold its value.
REQ-022 Latency: a tms sample at posedge N SHALL be reflected in tap_state after posedge N, and in tdo/tdo_en at the following negedge.
REQ-023 capture_dr, shift_dr and update_dr SHALL each be high exactly for the corresponding DR state; at most one SHALL be high at a time.

Reset
REQ-024 trstn=0 SHALL asynchronously force tap_state=TEST_LOGIC_RESET, tdo=0 and tdo_en=0.
REQ-025 While trstn=0, tlr SHALL be 1 and all DR strobes SHALL be 0.
REQ-026 Reset asserted mid-shift SHALL abort the operation without generating any update strobe.
REQ-027 After trstn deasserts, the first posedge SHALL apply REQ-014/REQ-015 from TEST_LOGIC_RESET.

Structure
REQ-028 tap_ctrl_fsm_t (all 16 states) SHALL reside in jtag_pkg and be shared with instruction_register and the data registers.
REQ-029 The negedge TDO mux/register SHALL be a sub-module, tap_tdo_out; the FSM and decode SHALL stay in tap_controller.

Verification
REQ-030 trstn pulsed low mid-SHIFT_DR -> tap_state=TEST_LOGIC_RESET immediately, tdo_en=0, no update_dr pulse.
REQ-031 From each of the 16 states, tms=1 for 5 tck -> TEST_LOGIC_RESET reached, tlr=1.
REQ-032 From TLR, tms=0,1,1,0,0 -> RTI, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR; tdo_en=1 at the next negedge; tdo follows ir_tdo.
REQ-033 From TLR, tms=0,1,0,0,0,0,1,1 -> capture_dr for 1 cycle, shift_dr for 3 cycles, update_dr for 1 cycle; tdo_en=0 at the negedge after EXIT1_DR.
REQ-034 In SHIFT_DR, toggle tms 1,0,1,0 (EXIT1, PAUSE, EXIT2, SHIFT) -> tdo holds its value while paused, and shifting resumes with tdo_en=1.
REQ-035 Force an illegal state encoding via a bench backdoor -> tap_state=TEST_LOGIC_RESET after 1 posedge.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_pkg : TAP controller state type shared by all JTAG blocks        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package jtag_pkg;

  // Five-bit encoding leaves 16 spare codes that the FSM treats as corrupt.
  typedef enum logic [4:0] {
    TEST_LOGIC_RESET = 5'd0,
    RUN_TEST_IDLE    = 5'd1,
    SELECT_DR_SCAN   = 5'd2,
    CAPTURE_DR       = 5'd3,
    SHIFT_DR         = 5'd4,
    EXIT1_DR         = 5'd5,
    PAUSE_DR         = 5'd6,
    EXIT2_DR         = 5'd7,
    UPDATE_DR        = 5'd8,
    SELECT_IR_SCAN   = 5'd9,
    CAPTURE_IR       = 5'd10,
    SHIFT_IR         = 5'd11,
    EXIT1_IR         = 5'd12,
    PAUSE_IR         = 5'd13,
    EXIT2_IR         = 5'd14,
    UPDATE_IR        = 5'd15
  } tap_ctrl_fsm_t;

  function automatic logic is_shift(input tap_ctrl_fsm_t state);
    return (state == SHIFT_DR) || (state == SHIFT_IR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_controller_if : serial/select inputs and state/strobe outputs     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface tap_controller_if;
  import jtag_pkg::*;

  logic          tms;
  logic          select_dr;
  logic          ir_tdo;
  logic          dr_tdo;
  tap_ctrl_fsm_t tap_state;
  logic          tdo;
  logic          tdo_en;
  logic          capture_dr;
  logic          shift_dr;
  logic          update_dr;
  logic          tlr;

  modport master (
    input  tms, select_dr, ir_tdo, dr_tdo,
    output tap_state, tdo, tdo_en, capture_dr, shift_dr, update_dr, tlr
  );

  modport slave (
    output tms, select_dr, ir_tdo, dr_tdo,
    input  tap_state, tdo, tdo_en, capture_dr, shift_dr, update_dr, tlr
  );
endinterface
`default_nettype wire

// File: rtl/tap_tdo_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_tdo_out : falling-edge TDO mux/register and driver enable         |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tap_tdo_out (
  input  wire logic tck,
  input  wire logic trstn,
  input  wire logic shifting,
  input  wire logic select_dr,
  input  wire logic ir_tdo,
  input  wire logic dr_tdo,
  output logic      tdo,
  output logic      tdo_en
);

  logic w_mux;
  logic r_tdo;
  logic r_tdo_en;

  assign w_mux = select_dr ? dr_tdo : ir_tdo;

  // tdo keeps its last shifted bit outside the shift states.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= shifting;
      if (shifting) begin
        r_tdo <= w_mux;
      end
    end
  end

  assign tdo    = r_tdo;
  assign tdo_en = r_tdo_en;

endmodule
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_controller : IEEE 1149.1 16-state TAP FSM with DR strobe decode   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tap_controller
  import jtag_pkg::*;
(
  input wire logic         tck,
  input wire logic         trstn,
  tap_controller_if.master tap
);

  tap_ctrl_fsm_t r_state;
  tap_ctrl_fsm_t w_next_state;
  logic          w_shifting;

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_state <= TEST_LOGIC_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = TEST_LOGIC_RESET;
    case (r_state)
      TEST_LOGIC_RESET: w_next_state = tap.tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    w_next_state = tap.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   w_next_state = tap.tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       w_next_state = tap.tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         w_next_state = tap.tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         w_next_state = tap.tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         w_next_state = tap.tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         w_next_state = tap.tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        w_next_state = tap.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   w_next_state = tap.tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       w_next_state = tap.tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         w_next_state = tap.tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         w_next_state = tap.tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         w_next_state = tap.tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         w_next_state = tap.tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        w_next_state = tap.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      // Spare encodings recover through reset rather than wandering.
      default:          w_next_state = TEST_LOGIC_RESET;
    endcase
  end

  assign w_shifting     = is_shift(r_state);
  assign tap.tap_state  = r_state;
  assign tap.tlr        = (r_state == TEST_LOGIC_RESET);
  assign tap.capture_dr = (r_state == CAPTURE_DR);
  assign tap.shift_dr   = (r_state == SHIFT_DR);
  assign tap.update_dr  = (r_state == UPDATE_DR);

  tap_tdo_out u_tdo_out (
    .tck       (tck),
    .trstn     (trstn),
    .shifting  (w_shifting),
    .select_dr (tap.select_dr),
    .ir_tdo    (tap.ir_tdo),
    .dr_tdo    (tap.dr_tdo),
    .tdo       (tap.tdo),
    .tdo_en    (tap.tdo_en)
  );

endmodule
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tap_controller : scoreboard bench with directed TMS/TDO vectors    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tap_controller;
  import jtag_pkg::*;

  logic tck;
  logic trstn;

  tap_controller_if ifc ();

  tap_controller dut (
    .tck   (tck),
    .trstn (trstn),
    .tap   (ifc)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct {
    tap_ctrl_fsm_t state;
    logic          chk_tdo;
    logic          tdo;
    string         tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic upd_watch = 1'b0;
  logic upd_seen  = 1'b0;

  int            plen [16];
  logic [7:0]    pbits[16];
  tap_ctrl_fsm_t ptgt [16];

  function automatic void compare(input string tag, input tap_ctrl_fsm_t es,
                                  input logic ctdo, input logic etdo);
    logic en_e;
    logic ok;
    en_e = (es == SHIFT_DR) || (es == SHIFT_IR);
    ok = (ifc.tap_state === es) && (ifc.tdo_en === en_e) &&
         (ifc.tlr === (es == TEST_LOGIC_RESET)) &&
         (ifc.capture_dr === (es == CAPTURE_DR)) &&
         (ifc.shift_dr === (es == SHIFT_DR)) &&
         (ifc.update_dr === (es == UPDATE_DR)) &&
         (!ctdo || (ifc.tdo === etdo));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got state=%0d tdo_en=%b tdo=%b tlr=%b cap/shf/upd=%b%b%b, need state=%0d tdo_en=%b tdo=%b(chk=%b)",
               tag, ifc.tap_state, ifc.tdo_en, ifc.tdo, ifc.tlr, ifc.capture_dr,
               ifc.shift_dr, ifc.update_dr, es, en_e, etdo, ctdo);
    end
  endfunction

  // Monitor: outputs settle after each falling edge; pop one expectation there.
  initial begin
    exp_t e;
    forever begin
      @(negedge tck);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e.tag, e.state, e.chk_tdo, e.tdo);
      end
    end
  end

  always @(ifc.update_dr) begin
    if (upd_watch && (ifc.update_dr === 1'b1)) upd_seen = 1'b1;
  end

  // Called at negedge+2; drives tms for the next rising edge, returns at the following negedge+2.
  task automatic drive(input logic t, input logic chk, input tap_ctrl_fsm_t es,
                       input logic ctdo, input logic etdo, input string tag);
    exp_t e;
    ifc.tms = t;
    if (chk) begin
      e.state   = es;
      e.chk_tdo = ctdo;
      e.tdo     = etdo;
      e.tag     = tag;
      sb_q.push_back(e);
    end
    @(negedge tck);
    #2;
  endtask

  task automatic st(input logic t, input tap_ctrl_fsm_t es, input string tag);
    drive(t, 1'b1, es, 1'b0, 1'b0, tag);
  endtask

  task automatic stt(input logic t, input tap_ctrl_fsm_t es, input logic etdo, input string tag);
    drive(t, 1'b1, es, 1'b1, etdo, tag);
  endtask

  task automatic set_path(input int idx, input int len, input logic [7:0] bits,
                          input tap_ctrl_fsm_t tgt);
    plen[idx]  = len;
    pbits[idx] = bits;
    ptgt[idx]  = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got running need finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] bits;
    // LSB-first TMS paths from TEST_LOGIC_RESET to each state.
    set_path(0,  0, 8'd0,  TEST_LOGIC_RESET);
    set_path(1,  1, 8'd0,  RUN_TEST_IDLE);
    set_path(2,  2, 8'd2,  SELECT_DR_SCAN);
    set_path(3,  3, 8'd2,  CAPTURE_DR);
    set_path(4,  4, 8'd2,  SHIFT_DR);
    set_path(5,  4, 8'd10, EXIT1_DR);
    set_path(6,  5, 8'd10, PAUSE_DR);
    set_path(7,  6, 8'd42, EXIT2_DR);
    set_path(8,  5, 8'd26, UPDATE_DR);
    set_path(9,  3, 8'd6,  SELECT_IR_SCAN);
    set_path(10, 4, 8'd6,  CAPTURE_IR);
    set_path(11, 5, 8'd6,  SHIFT_IR);
    set_path(12, 5, 8'd22, EXIT1_IR);
    set_path(13, 6, 8'd22, PAUSE_IR);
    set_path(14, 7, 8'd86, EXIT2_IR);
    set_path(15, 6, 8'd54, UPDATE_IR);

    trstn         = 1'b1;
    ifc.tms       = 1'b1;
    ifc.select_dr = 1'b0;
    ifc.ir_tdo    = 1'b0;
    ifc.dr_tdo    = 1'b0;
    #1 trstn = 1'b0;
    #1 compare("reset_async", TEST_LOGIC_RESET, 1'b1, 1'b0);
    @(negedge tck);
    #2;
    compare("reset_hold", TEST_LOGIC_RESET, 1'b1, 1'b0);
    ifc.tms = 1'b0;
    trstn   = 1'b1;

    // IR scan: TLR -> RTI, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR; tdo follows ir_tdo.
    st(1'b0, RUN_TEST_IDLE,  "ir_rti");
    st(1'b1, SELECT_DR_SCAN, "ir_seldr");
    st(1'b1, SELECT_IR_SCAN, "ir_selir");
    st(1'b0, CAPTURE_IR,     "ir_cap");
    ifc.ir_tdo = 1'b1; ifc.dr_tdo = 1'b0;
    stt(1'b0, SHIFT_IR, 1'b1, "ir_shift0");
    ifc.ir_tdo = 1'b0; ifc.dr_tdo = 1'b1;
    stt(1'b0, SHIFT_IR, 1'b0, "ir_shift1");
    ifc.ir_tdo = 1'b1; ifc.dr_tdo = 1'b0;
    stt(1'b0, SHIFT_IR, 1'b1, "ir_shift2");
    ifc.ir_tdo = 1'b0;
    stt(1'b1, EXIT1_IR,  1'b1, "ir_exit1");
    stt(1'b1, UPDATE_IR, 1'b1, "ir_upd");
    stt(1'b0, RUN_TEST_IDLE, 1'b1, "ir_rti2");

    // DR scan: capture 1, shift 3, update 1; tdo follows dr_tdo.
    st(1'b1, SELECT_DR_SCAN,   "go_seldr");
    st(1'b1, SELECT_IR_SCAN,   "go_selir");
    stt(1'b1, TEST_LOGIC_RESET, 1'b1, "go_tlr");
    ifc.select_dr = 1'b1;
    st(1'b0, RUN_TEST_IDLE,  "dr_rti");
    st(1'b1, SELECT_DR_SCAN, "dr_seldr");
    st(1'b0, CAPTURE_DR,     "dr_cap");
    ifc.dr_tdo = 1'b0; ifc.ir_tdo = 1'b1;
    stt(1'b0, SHIFT_DR, 1'b0, "dr_shift0");
    ifc.dr_tdo = 1'b1; ifc.ir_tdo = 1'b0;
    stt(1'b0, SHIFT_DR, 1'b1, "dr_shift1");
    ifc.dr_tdo = 1'b0; ifc.ir_tdo = 1'b1;
    stt(1'b0, SHIFT_DR, 1'b0, "dr_shift2");
    ifc.dr_tdo = 1'b1;
    stt(1'b1, EXIT1_DR,  1'b0, "dr_exit1");
    stt(1'b1, UPDATE_DR, 1'b0, "dr_upd");
    stt(1'b0, RUN_TEST_IDLE, 1'b0, "dr_rti2");

    // Pause in the middle of a DR shift.
    st(1'b1, SELECT_DR_SCAN, "p_seldr");
    st(1'b0, CAPTURE_DR,     "p_cap");
    ifc.dr_tdo = 1'b1;
    stt(1'b0, SHIFT_DR, 1'b1, "p_shift");
    ifc.dr_tdo = 1'b0;
    stt(1'b1, EXIT1_DR, 1'b1, "p_exit1");
    stt(1'b0, PAUSE_DR, 1'b1, "p_pause0");
    stt(1'b0, PAUSE_DR, 1'b1, "p_pause1");
    stt(1'b1, EXIT2_DR, 1'b1, "p_exit2");
    stt(1'b0, SHIFT_DR, 1'b0, "p_resume0");
    ifc.dr_tdo = 1'b1;
    stt(1'b0, SHIFT_DR, 1'b1, "p_resume1");
    stt(1'b1, EXIT1_DR, 1'b1, "p_exit1b");
    stt(1'b1, UPDATE_DR, 1'b1, "p_upd");
    stt(1'b0, RUN_TEST_IDLE, 1'b1, "p_rti");

    // Reset pulsed mid SHIFT_DR: immediate abort, no update strobe.
    st(1'b1, SELECT_DR_SCAN, "r_seldr");
    st(1'b0, CAPTURE_DR,     "r_cap");
    ifc.dr_tdo = 1'b1;
    stt(1'b0, SHIFT_DR, 1'b1, "r_shift");
    upd_watch = 1'b1;
    ifc.tms   = 1'b1;
    #1 trstn = 1'b0;
    #1 compare("rst_mid_shift", TEST_LOGIC_RESET, 1'b1, 1'b0);
    @(negedge tck);
    #2;
    compare("rst_mid_hold", TEST_LOGIC_RESET, 1'b1, 1'b0);
    ifc.tms = 1'b0;
    trstn   = 1'b1;
    stt(1'b0, RUN_TEST_IDLE, 1'b0, "rst_rti0");
    stt(1'b0, RUN_TEST_IDLE, 1'b0, "rst_rti1");
    upd_watch = 1'b0;
    n_vec++;
    if (upd_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_update: got update_dr pulse=%b need 0", upd_seen);
    end

    // Five TMS=1 edges reach TLR from every state.
    for (int k = 0; k < 5; k++) drive(1'b1, (k == 4), TEST_LOGIC_RESET, 1'b0, 1'b0, "pre_tlr");
    for (int i = 0; i < 16; i++) begin
      bits = pbits[i];
      for (int k = 0; k < plen[i]; k++)
        drive(bits[k], (k == plen[i] - 1), ptgt[i], 1'b0, 1'b0, $sformatf("path%0d", i));
      for (int k = 0; k < 5; k++)
        drive(1'b1, (k == 4), TEST_LOGIC_RESET, 1'b0, 1'b0, $sformatf("tlr_from%0d", i));
    end

    // Corrupt encoding recovers to TLR on the next edge (RTI+tms=0 would otherwise stay).
    st(1'b0, RUN_TEST_IDLE, "bd_rti");
    dut.r_state = tap_ctrl_fsm_t'(5'h1f);
    st(1'b0, TEST_LOGIC_RESET, "bd_recover");
    st(1'b0, RUN_TEST_IDLE,    "bd_rti2");

    @(negedge tck);
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations need 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
